// File: rtl/axi4_lite_read_slave_responder.sv
// axi4_lite_read_slave_responder: AXI4-Lite read slave with an in-order AR FIFO and backdoor-loaded word memory.
// Define AXI4LITE_READ_PROT_CHECK_EN to answer unprivileged reads (arprot[0]==0) with SLVERR.
module axi4_lite_read_slave_responder #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int OUTSTANDING_DEPTH = 10,
  parameter int MEM_DEPTH = 64,
  parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS = 'h01,
  parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDRESS = 'hff,
  parameter int DELAY_WIDTH = 5
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [ADDRESS_WIDTH-1:0]            araddr,
  input  logic [2:0]                          arprot,
  input  logic                                arvalid,
  output logic                                arready,
  output logic [DATA_WIDTH-1:0]               rdata,
  output logic [1:0]                          rresp,
  output logic                                rvalid,
  input  logic                                rready,
  input  logic [DELAY_WIDTH-1:0]              rvalidDelay,
  input  logic                                memWrEn,
  input  logic [$clog2(MEM_DEPTH)-1:0]        memWrIdx,
  input  logic [DATA_WIDTH-1:0]               memWrData,
  output logic [$clog2(OUTSTANDING_DEPTH):0]  outstandingCount
);
  localparam int BL = $clog2(DATA_WIDTH / 8);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam int PW = OUTSTANDING_DEPTH > 1 ? $clog2(OUTSTANDING_DEPTH) : 1;
  localparam int CW = $clog2(OUTSTANDING_DEPTH) + 1;
`ifdef AXI4LITE_READ_PROT_CHECK_EN
  localparam logic [2:0] PROT_REQ = 3'b001;
`else
  localparam logic [2:0] PROT_REQ = 3'b000;
`endif
  typedef enum logic [1:0] {IDLE, DELAY, VALID} state_t;
  state_t state, state_next;
  logic [ADDRESS_WIDTH-1:0] fifo_addr [OUTSTANDING_DEPTH];
  logic [2:0] fifo_prot [OUTSTANDING_DEPTH];
  logic fifo_err [OUTSTANDING_DEPTH];
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [DELAY_WIDTH-1:0] dly_cnt;
  logic [IW-1:0] head_idx;
  logic run, avail, push, pop, addr_err, head_err;
  assign addr_err = araddr < MIN_ADDRESS || araddr > MAX_ADDRESS || araddr[BL-1:0] != '0 ||
                    (araddr >> BL) >= ADDRESS_WIDTH'(MEM_DEPTH);
  assign arready = run && count != CW'(OUTSTANDING_DEPTH);
  assign push = arvalid && arready;
  assign pop = rvalid && rready;
  assign outstandingCount = count;
  assign head_idx = IW'(fifo_addr[rd_ptr] >> BL);
  assign head_err = fifo_err[rd_ptr] || (~fifo_prot[rd_ptr] & PROT_REQ) != 3'b000;
  // avail lags a push by one cycle so the FSM only sees entries that settled a full cycle earlier
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      run <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      avail <= 1'b0;
    end else begin
      run <= 1'b1;
      if (push) wr_ptr <= wr_ptr == PW'(OUTSTANDING_DEPTH - 1) ? '0 : wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr == PW'(OUTSTANDING_DEPTH - 1) ? '0 : rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      avail <= count != CW'(pop);
    end
  always_ff @(posedge aclk)
    if (push) begin
      fifo_addr[wr_ptr] <= araddr;
      fifo_prot[wr_ptr] <= arprot;
      fifo_err[wr_ptr] <= addr_err;
    end
  always_ff @(posedge aclk)
    if (memWrEn) mem[memWrIdx] <= memWrData;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (avail) state_next = rvalidDelay == '0 ? VALID : DELAY;
      DELAY:   if (dly_cnt == DELAY_WIDTH'(1)) state_next = VALID;
      VALID:   if (rready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
  always_comb rvalid = state == VALID;
  // response is captured on the VALID-entry edge, so a same-edge backdoor write is not seen
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      dly_cnt <= '0;
      rdata <= '0;
      rresp <= 2'b00;
    end else begin
      if (state == IDLE) dly_cnt <= rvalidDelay;
      else if (state == DELAY) dly_cnt <= dly_cnt - DELAY_WIDTH'(1);
      if (state != VALID && state_next == VALID) begin
        rdata <= head_err ? '0 : mem[head_idx];
        rresp <= head_err ? 2'b10 : 2'b00;
      end
    end
endmodule

// File: tb/tb_axi4_lite_read_slave_responder.sv
// tb_axi4_lite_read_slave_responder: randomized bench with an address-rule reference model and in-order scoreboard.
module tb_axi4_lite_read_slave_responder;
  localparam int MD = 64;
  logic aclk = 1'b0, aresetn = 1'b0;
  logic [31:0] araddr = '0;
  logic [2:0] arprot = 3'b001;
  logic arvalid = 1'b0, rready = 1'b0, memWrEn = 1'b0;
  logic arready, rvalid;
  logic [31:0] rdata, memWrData = '0;
  logic [1:0] rresp;
  logic [4:0] rvalidDelay = '0;
  logic [5:0] memWrIdx = '0;
  logic [4:0] outstandingCount;
  int checks = 0, failures = 0;
  logic [31:0] tb_mem [MD];
  logic [34:0] acc_q [$];
  logic [33:0] obs_q [$];

  always #5 aclk = ~aclk;

  axi4_lite_read_slave_responder dut (
    .aclk(aclk), .aresetn(aresetn), .araddr(araddr), .arprot(arprot), .arvalid(arvalid),
    .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .rvalidDelay(rvalidDelay), .memWrEn(memWrEn), .memWrIdx(memWrIdx), .memWrData(memWrData),
    .outstandingCount(outstandingCount)
  );

  always @(posedge aclk)
    if (aresetn) begin
      if (arvalid && arready) acc_q.push_back({araddr, arprot});
      if (rvalid && rready) obs_q.push_back({rdata, rresp});
    end

  function automatic logic [33:0] model(input logic [34:0] req);
    logic [31:0] a;
    bit err;
    a = req[34:3];
    err = a < 1 || a > 'hff || a % 4 != 0 || a / 4 >= MD;
`ifdef AXI4LITE_READ_PROT_CHECK_EN
    if (req[0] == 1'b0) err = 1'b1;
`endif
    return err ? {32'h0, 2'b10} : {tb_mem[6'(a / 4)], 2'b00};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [2:0] p, output bit ok);
    araddr = a;
    arprot = p;
    arvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      ok = arready;
      tick();
    end
    arvalid = 1'b0;
  endtask

  task automatic wait_beats(input int n, output bit ok);
    for (int i = 0; i < 2000 && obs_q.size() < n; i++) tick();
    ok = obs_q.size() >= n;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    memWrEn = 1'b1;
    for (int i = 0; i < MD; i++) begin
      tb_mem[i] = $urandom;
      memWrIdx = 6'(i);
      memWrData = tb_mem[i];
      tick();
    end
    tb_mem[4] = 32'hDEAD_BEEF;
    memWrIdx = 6'd4;
    memWrData = 32'hDEAD_BEEF;
    tick();
    memWrEn = 1'b0;
    checks++; if (arready !== 1'b0) begin failures++; $display("FAIL reset_arready got=%b exp=0", arready); end
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if (rresp !== 2'b00) begin failures++; $display("FAIL reset_rresp got=%b exp=00", rresp); end
    checks++; if (outstandingCount !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", outstandingCount); end
    aresetn = 1'b1;
    tick();
    tick();
    checks++; if (arready !== 1'b1) begin failures++; $display("FAIL release_arready got=%b exp=1", arready); end
  endtask

  task automatic test_single();
    acc_q.delete(); obs_q.delete();
    rvalidDelay = '0;
    rready = 1'b1;
    araddr = 32'h10;
    arprot = 3'b001;
    arvalid = 1'b1;
    checks++; if (arready !== 1'b1) begin failures++; $display("FAIL single_arready got=%b exp=1", arready); end
    tick();
    arvalid = 1'b0;
    checks++; if (outstandingCount !== 5'd1) begin failures++; $display("FAIL single_count1 got=%0d exp=1", outstandingCount); end
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL single_rvalid_n0 got=%b exp=0", rvalid); end
    tick();
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL single_rvalid_n1 got=%b exp=0", rvalid); end
    tick();
    checks++; if (rvalid !== 1'b1) begin failures++; $display("FAIL single_rvalid_n2 got=%b exp=1", rvalid); end
    checks++; if (rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_rdata got=%h exp=deadbeef", rdata); end
    checks++; if (rresp !== 2'b00) begin failures++; $display("FAIL single_rresp got=%b exp=00", rresp); end
    tick();
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL single_rvalid_after got=%b exp=0", rvalid); end
    checks++; if (outstandingCount !== 5'd0) begin failures++; $display("FAIL single_count0 got=%0d exp=0", outstandingCount); end
  endtask

  task automatic test_errors();
    bit ok;
    acc_q.delete(); obs_q.delete();
    rready = 1'b1;
    send(32'h100, 3'b001, ok);
    send(32'h000, 3'b001, ok);
    send(32'h012, 3'b001, ok);
    wait_beats(3, ok);
    checks++; if (!ok || acc_q.size() != 3) begin failures++; $display("FAIL err_beats got=%0d exp=3", obs_q.size()); end
    for (int i = 0; i < 3 && i < obs_q.size() && i < acc_q.size(); i++) begin
      checks++; if (obs_q[i] !== {32'h0, 2'b10} || obs_q[i] !== model(acc_q[i])) begin failures++; $display("FAIL err_resp%0d got=%h exp=%h", i, obs_q[i], {32'h0, 2'b10}); end
    end
  endtask

  task automatic test_fill();
    bit ok;
    logic [33:0] exp;
    acc_q.delete(); obs_q.delete();
    rready = 1'b0;
    rvalidDelay = '0;
    arprot = 3'b001;
    arvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      araddr = 32'(4 * (i + 1));
      checks++; if (arready !== 1'b1) begin failures++; $display("FAIL fill_arready%0d got=%b exp=1", i, arready); end
      tick();
    end
    araddr = 32'h2c;
    checks++; if (arready !== 1'b0) begin failures++; $display("FAIL fill_full_arready got=%b exp=0", arready); end
    checks++; if (outstandingCount !== 5'd10) begin failures++; $display("FAIL fill_count got=%0d exp=10", outstandingCount); end
    tick();
    tick();
    checks++; if (arready !== 1'b0 || rvalid !== 1'b1) begin failures++; $display("FAIL fill_hold got=%b%b exp=01", arready, rvalid); end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    checks++; if (arready !== 1'b1) begin failures++; $display("FAIL fill_rise got=%b exp=1", arready); end
    checks++; if (outstandingCount !== 5'd9) begin failures++; $display("FAIL fill_pop_count got=%0d exp=9", outstandingCount); end
    tick();
    arvalid = 1'b0;
    checks++; if (outstandingCount !== 5'd10 || arready !== 1'b0) begin failures++; $display("FAIL fill_11th got=%0d/%b exp=10/0", outstandingCount, arready); end
    rready = 1'b1;
    wait_beats(11, ok);
    checks++; if (!ok || acc_q.size() != 11) begin failures++; $display("FAIL fill_beats got=%0d exp=11", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < acc_q.size(); i++) begin
      exp = model(acc_q[i]);
      checks++; if (obs_q[i] !== exp || acc_q[i][34:3] !== 32'(4 * (i + 1))) begin failures++; $display("FAIL fill_beat%0d got=%h exp=%h", i, obs_q[i], exp); end
    end
  endtask

  task automatic test_delay_backpressure();
    logic [33:0] exp;
    logic [31:0] nv;
    acc_q.delete(); obs_q.delete();
    rvalidDelay = 5'd3;
    rready = 1'b0;
    exp = model({32'h20, 3'b001});
    araddr = 32'h20;
    arprot = 3'b001;
    arvalid = 1'b1;
    checks++; if (arready !== 1'b1) begin failures++; $display("FAIL dly_arready got=%b exp=1", arready); end
    tick();
    arvalid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL dly_early_n%0d got=%b exp=0", k, rvalid); end
    end
    tick();
    nv = ~tb_mem[8];
    memWrEn = 1'b1;
    memWrIdx = 6'd8;
    memWrData = nv;
    for (int k = 0; k < 5; k++) begin
      checks++; if (rvalid !== 1'b1 || {rdata, rresp} !== exp) begin failures++; $display("FAIL dly_hold%0d got=%b/%h exp=1/%h", k, rvalid, {rdata, rresp}, exp); end
      tick();
      memWrEn = 1'b0;
    end
    tb_mem[8] = nv;
    rready = 1'b1;
    tick();
    checks++; if (rvalid !== 1'b0 || outstandingCount !== 5'd0) begin failures++; $display("FAIL dly_pop got=%b/%0d exp=0/0", rvalid, outstandingCount); end
    checks++; if (obs_q.size() != 1 || obs_q[0] !== exp) begin failures++; $display("FAIL dly_beat got=%0d exp=1", obs_q.size()); end
    rvalidDelay = '0;
  endtask

  task automatic test_collision();
    bit ok;
    logic [33:0] old_exp, new_exp;
    logic [31:0] nv;
    acc_q.delete(); obs_q.delete();
    rready = 1'b0;
    old_exp = model({32'h30, 3'b001});
    send(32'h30, 3'b001, ok);
    tick();
    nv = tb_mem[12] ^ 32'h5A5A_A5A5;
    memWrEn = 1'b1;
    memWrIdx = 6'd12;
    memWrData = nv;
    tick();
    memWrEn = 1'b0;
    tb_mem[12] = nv;
    checks++; if (rvalid !== 1'b1 || {rdata, rresp} !== old_exp) begin failures++; $display("FAIL coll_old got=%b/%h exp=1/%h", rvalid, {rdata, rresp}, old_exp); end
    rready = 1'b1;
    tick();
    obs_q.delete(); acc_q.delete();
    new_exp = model({32'h30, 3'b001});
    send(32'h30, 3'b001, ok);
    wait_beats(1, ok);
    checks++; if (!ok || obs_q[0] !== new_exp) begin failures++; $display("FAIL coll_new got=%h exp=%h", ok ? obs_q[0] : 34'h0, new_exp); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    acc_q.delete(); obs_q.delete();
    rready = 1'b0;
    send(32'h04, 3'b001, ok);
    send(32'h08, 3'b001, ok);
    send(32'h0c, 3'b001, ok);
    for (int i = 0; i < 20 && !rvalid; i++) tick();
    checks++; if (rvalid !== 1'b1 || outstandingCount !== 5'd3) begin failures++; $display("FAIL rmid_pre got=%b/%0d exp=1/3", rvalid, outstandingCount); end
    #1 aresetn = 1'b0;
    #1;
    checks++; if (rvalid !== 1'b0 || outstandingCount !== 5'd0 || arready !== 1'b0) begin failures++; $display("FAIL rmid_async got=%b/%0d/%b exp=0/0/0", rvalid, outstandingCount, arready); end
    tick();
    tick();
    aresetn = 1'b1;
    acc_q.delete(); obs_q.delete();
    tick();
    rready = 1'b1;
    send(32'h40, 3'b001, ok);
    wait_beats(1, ok);
    for (int i = 0; i < 10; i++) tick();
    checks++; if (!ok || obs_q.size() != 1 || acc_q.size() != 1) begin failures++; $display("FAIL rmid_beats got=%0d exp=1", obs_q.size()); end
    checks++; if (obs_q.size() < 1 || obs_q[0] !== {tb_mem[16], 2'b00}) begin failures++; $display("FAIL rmid_data got=%h exp=%h", obs_q.size() > 0 ? obs_q[0] : 34'h0, {tb_mem[16], 2'b00}); end
  endtask

  task automatic test_prot();
    bit ok;
    acc_q.delete(); obs_q.delete();
    rready = 1'b1;
    send(32'h10, 3'b000, ok);
    send(32'h10, 3'b001, ok);
    wait_beats(2, ok);
    checks++; if (!ok || acc_q.size() != 2) begin failures++; $display("FAIL prot_beats got=%0d exp=2", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < acc_q.size(); i++) begin
      checks++; if (obs_q[i] !== model(acc_q[i])) begin failures++; $display("FAIL prot_resp%0d got=%h exp=%h", i, obs_q[i], model(acc_q[i])); end
    end
    checks++; if (obs_q.size() > 1 && obs_q[1] !== {32'hDEAD_BEEF, 2'b00}) begin failures++; $display("FAIL prot_priv got=%h exp=deadbeef/00", obs_q[1]); end
  endtask

  task automatic test_random();
    bit ok;
    int sent;
    logic [33:0] exp;
    acc_q.delete(); obs_q.delete();
    sent = 0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          send($urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 'h1ff)) : 32'(4 * $urandom_range(1, 63)), 3'($urandom), ok);
          if (ok) sent++;
        end
      end
      begin
        for (int c = 0; c < 400; c++) begin
          rready = 1'($urandom);
          rvalidDelay = $urandom_range(0, 3) == 0 ? 5'($urandom_range(0, 4)) : 5'd0;
          tick();
        end
      end
    join
    rready = 1'b1;
    rvalidDelay = '0;
    wait_beats(30, ok);
    checks++; if (!ok || sent != 30 || acc_q.size() != 30) begin failures++; $display("FAIL rand_count got=%0d/%0d exp=30", sent, obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < acc_q.size(); i++) begin
      exp = model(acc_q[i]);
      checks++; if (obs_q[i] !== exp) begin failures++; $display("FAIL rand_beat%0d addr=%h got=%h exp=%h", i, acc_q[i][34:3], obs_q[i], exp); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_errors();
    test_fill();
    test_delay_backpressure();
    test_collision();
    test_reset_mid();
    test_prot();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
